grant_xfer_ctrl: RTL

Transfer controller that sits directly downstream of the 4-requester arbiter. It takes the arbiter's registered one-hot `grant[3:0]` and locks ownership of a shared valid/ready sink to the granted requester. It then steers that requester's data beats through to the sink until its burst ends, a beat limit is hit, or the source stalls. Grant changes are ignored while a burst is in flight, so the arbiter can keep re-evaluating every cycle without tearing transfers.

---
 rtl/grant_xfer_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/grant_xfer_ctrl.sv
// Locks a shared valid/ready sink to the arbiter's granted requester for one burst.
// Optional `GRANT_ONEHOT_CHECK_EN: reject multi-hot grants in IDLE and pulse err_grant.
module grant_xfer_ctrl #(
   parameter int DW           = 8,
   parameter int MAX_BEATS    = 16,
   parameter int IDLE_TIMEOUT = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      grant,
   input  logic [3:0]      src_valid,
   input  logic [4*DW-1:0] src_data,
   input  logic [3:0]      src_last,
   output logic [3:0]      src_ready,
   output logic            m_valid,
   output logic [DW-1:0]   m_data,
   output logic            m_last,
   input  logic            m_ready,
   output logic [1:0]      m_src,
   output logic            busy,
   output logic            xfer_done,
   output logic            xfer_abort,
   output logic            err_grant
);

   localparam int BW = $clog2(MAX_BEATS);
   localparam int SW = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t         r_state;
   logic [1:0]     r_owner;
   logic [BW-1:0]  r_beat_cnt;
   logic [SW-1:0]  r_stall_cnt;
   logic           r_busy;
   logic           r_done;
   logic           r_abort;

   logic           w_xfer;
   logic           w_own_valid;
   logic           w_own_last;
   logic           w_limit;
   logic           w_stall_to;
   logic           w_accept;
   logic           w_grant_ok;
   logic [1:0]     w_enc;

   assign w_xfer      = (r_state == XFER);
   assign w_own_valid = src_valid[r_owner];
   assign w_own_last  = src_last[r_owner];
   assign w_limit     = (r_beat_cnt == BW'(MAX_BEATS - 1));
   assign w_stall_to  = (r_stall_cnt == SW'(IDLE_TIMEOUT - 1));

   // Lowest set bit wins; for a clean one-hot grant this is a plain encode.
   always_comb begin
      w_enc = 2'd0;
      if (grant[0])      w_enc = 2'd0;
      else if (grant[1]) w_enc = 2'd1;
      else if (grant[2]) w_enc = 2'd2;
      else if (grant[3]) w_enc = 2'd3;
   end

`ifdef GRANT_ONEHOT_CHECK_EN
   logic w_multi;
   logic r_err;
   assign w_multi    = |(grant & (grant - 4'd1));
   assign w_grant_ok = (grant != 4'd0) && !w_multi;
   assign err_grant  = r_err;
`else
   assign w_grant_ok = (grant != 4'd0);
   assign err_grant  = 1'b0;
`endif

   always_comb begin
      src_ready = 4'd0;
      m_valid   = w_xfer & w_own_valid;
      m_data    = w_xfer ? src_data[r_owner*DW +: DW] : '0;
      m_last    = m_valid & (w_own_last | w_limit);
      if (w_xfer) src_ready[r_owner] = m_ready;
   end

   assign w_accept   = m_valid & m_ready;
   assign m_src      = r_owner;
   assign busy       = r_busy;
   assign xfer_done  = r_done;
   assign xfer_abort = r_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= 2'd0;
         r_beat_cnt  <= '0;
         r_stall_cnt <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_abort     <= 1'b0;
`ifdef GRANT_ONEHOT_CHECK_EN
         r_err       <= 1'b0;
`endif
      end else begin
         r_done  <= 1'b0;
         r_abort <= 1'b0;
`ifdef GRANT_ONEHOT_CHECK_EN
         r_err   <= 1'b0;
`endif
         unique case (r_state)
            IDLE: begin
`ifdef GRANT_ONEHOT_CHECK_EN
               r_err <= w_multi;
`endif
               if (w_grant_ok) begin
                  r_owner     <= w_enc;
                  r_beat_cnt  <= '0;
                  r_stall_cnt <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= XFER;
               end
            end
            XFER: begin
               if (w_accept) r_beat_cnt <= r_beat_cnt + BW'(1);
               // Backpressure with valid high is not a stall.
               if (w_own_valid) r_stall_cnt <= '0;
               else             r_stall_cnt <= r_stall_cnt + SW'(1);
               if (w_accept && m_last) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (!w_own_valid && w_stall_to) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_abort <= 1'b1;
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
